spi_ram_master: RTL and testbench

//  Host-side SPI master that sequences byte transactions to the SPI RAM slave (SPI_WRAPPER).

---
 rtl/spi_ram_master_if.sv | 22 ++
 rtl/spi_ram_master.sv | 196 +++++++++++++++++++
 tb/tb_spi_ram_master.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_master_if.sv
// Host-side request/response bundle of the SPI RAM master.
// The master modport is the requester; the slave modport is the SPI master block itself.
interface spi_ram_master_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/spi_ram_master.sv
// Bit-serial SPI master turning one host byte request into the RAM slave's
// address-frame / data-frame sequence, with optional per-direction address caching.
//
// state   | meaning
// IDLE    | ready for a request, SS_n high
// START   | first low cycle of a frame, MOSI = direction bit
// SHIFT   | 10 cycles shifting {cmd, payload} MSB first
// WAIT_RD | turnaround before the slave drives MISO
// RECV    | 8 cycles sampling MISO, MSB first
// RESP    | rsp_valid pulse with the captured byte
// GAP     | SS_n high between frames / after a transaction
module spi_ram_master #(
    parameter int GAP_CYCLES = 2,
    parameter int READ_WAIT  = 2,
    parameter int ADDR_CACHE = 1
) (
    input  logic            clk,
    input  logic            rst,
    spi_ram_master_if.slave host,
    output logic            SS_n,
    output logic            MOSI,
    input  logic            MISO
);
    typedef enum logic [2:0] {IDLE, START, SHIFT, WAIT_RD, RECV, RESP, GAP} state_t;

    localparam logic [15:0] GAP_LD   = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] WAIT_LD  = 16'((READ_WAIT > 0) ? READ_WAIT - 1 : 0);
    localparam logic [15:0] SHIFT_LD = 16'd9;
    localparam logic [15:0] RECV_LD  = 16'd7;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [9:0]  frame_q, frame_d;
    logic        is_addr_q, is_addr_d;
    logic        wr_q, wr_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [6:0]  rx_q, rx_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        wr_cv_q, wr_cv_d;
    logic        rd_cv_q, rd_cv_d;
    logic [7:0]  wr_ca_q, wr_ca_d;
    logic [7:0]  rd_ca_q, rd_ca_d;
    logic        hit;

    function automatic logic [9:0] addr_frame(input logic wr, input logic [7:0] a);
        return {~wr, 1'b0, a};
    endfunction

    function automatic logic [9:0] data_frame(input logic wr, input logic [7:0] d);
        return wr ? {2'b01, d} : {2'b11, 8'h00};
    endfunction

    always_comb begin
        hit = 1'b0;
        if (ADDR_CACHE != 0) begin
            hit = host.req_write ? (wr_cv_q && (wr_ca_q == host.req_addr))
                                 : (rd_cv_q && (rd_ca_q == host.req_addr));
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        frame_d   = frame_q;
        is_addr_d = is_addr_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        wr_cv_d   = wr_cv_q;
        rd_cv_d   = rd_cv_q;
        wr_ca_d   = wr_ca_q;
        rd_ca_d   = rd_ca_q;

        case (state_q)
            IDLE: begin
                if (host.req_valid) begin
                    wr_d      = host.req_write;
                    addr_d    = host.req_addr;
                    wdata_d   = host.req_wdata;
                    is_addr_d = ~hit;
                    frame_d   = hit ? data_frame(host.req_write, host.req_wdata)
                                    : addr_frame(host.req_write, host.req_addr);
                    state_d   = START;
                end
            end
            START: begin
                state_d = SHIFT;
                cnt_d   = SHIFT_LD;
            end
            SHIFT: begin
                frame_d = {frame_q[8:0], 1'b0};
                cnt_d   = cnt_q - 16'd1;
                if (cnt_q == 16'd0) begin
                    if (is_addr_q) begin
                        // cache only becomes valid once the slave has the full address
                        if (wr_q) begin
                            wr_cv_d = 1'b1;
                            wr_ca_d = addr_q;
                        end else begin
                            rd_cv_d = 1'b1;
                            rd_ca_d = addr_q;
                        end
                        state_d = GAP;
                        cnt_d   = GAP_LD;
                    end else if (!wr_q) begin
                        if (READ_WAIT > 0) begin
                            state_d = WAIT_RD;
                            cnt_d   = WAIT_LD;
                        end else begin
                            state_d = RECV;
                            cnt_d   = RECV_LD;
                        end
                    end else begin
                        state_d = GAP;
                        cnt_d   = GAP_LD;
                    end
                end
            end
            WAIT_RD: begin
                cnt_d = cnt_q - 16'd1;
                if (cnt_q == 16'd0) begin
                    state_d = RECV;
                    cnt_d   = RECV_LD;
                end
            end
            RECV: begin
                rx_d  = {rx_q[5:0], MISO};
                cnt_d = cnt_q - 16'd1;
                if (cnt_q == 16'd0) begin
                    rdata_d = {rx_q, MISO};
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = GAP;
                cnt_d   = GAP_LD;
            end
            GAP: begin
                cnt_d = cnt_q - 16'd1;
                if (cnt_q == 16'd0) begin
                    if (is_addr_q) begin
                        is_addr_d = 1'b0;
                        frame_d   = data_frame(wr_q, wdata_q);
                        state_d   = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            frame_q   <= '0;
            is_addr_q <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rx_q      <= '0;
            rdata_q   <= '0;
            wr_cv_q   <= 1'b0;
            rd_cv_q   <= 1'b0;
            wr_ca_q   <= '0;
            rd_ca_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            frame_q   <= frame_d;
            is_addr_q <= is_addr_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rx_q      <= rx_d;
            rdata_q   <= rdata_d;
            wr_cv_q   <= wr_cv_d;
            rd_cv_q   <= rd_cv_d;
            wr_ca_q   <= wr_ca_d;
            rd_ca_q   <= rd_ca_d;
        end
    end

    // START repeats W[9] so the slave sees the direction before the frame word proper
    assign SS_n           = (state_q == IDLE) || (state_q == GAP);
    assign MOSI           = ((state_q == START) || (state_q == SHIFT)) && frame_q[9];
    assign host.req_ready = (state_q == IDLE);
    assign host.busy      = (state_q != IDLE);
    assign host.rsp_valid = (state_q == RESP);
    assign host.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: a frame-level RAM slave model plus a request-level
// reference (expected frames, latency, read data) driven by directed and random requests.
module tb_spi_ram_master;
    localparam int G = 2;
    localparam int R = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ss_n, mosi;
    logic miso = 1'b0;
    logic ss_n_nc, mosi_nc;
    logic miso_nc = 1'b0;
    int   cyc = 0;

    spi_ram_master_if hif();
    spi_ram_master_if hif_nc();

    spi_ram_master #(.GAP_CYCLES(G), .READ_WAIT(R), .ADDR_CACHE(1)) dut (
        .clk(clk), .rst(rst), .host(hif), .SS_n(ss_n), .MOSI(mosi), .MISO(miso)
    );

    spi_ram_master #(.GAP_CYCLES(G), .READ_WAIT(R), .ADDR_CACHE(0)) dut_nc (
        .clk(clk), .rst(rst), .host(hif_nc), .SS_n(ss_n_nc), .MOSI(mosi_nc), .MISO(miso_nc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference state: RAM contents and the address each direction last delivered
    logic [7:0]  smem    [256];
    logic [7:0]  exp_mem [256];
    logic [10:0] exp_q[$];
    logic [7:0]  rsp_q[$];
    bit          m_wr_v, m_rd_v;
    logic [7:0]  m_wr_a, m_rd_a;

    task automatic model_req(input bit wr, input logic [7:0] a, input logic [7:0] d,
                             output int lat, output logic [7:0] rd);
        bit hit;
        hit = wr ? (m_wr_v && m_wr_a == a) : (m_rd_v && m_rd_a == a);
        lat = 11 + G;
        rd  = 8'h00;
        if (!hit) begin
            exp_q.push_back(wr ? {1'b0, 2'b00, a} : {1'b1, 2'b10, a});
            lat += 11 + G;
        end
        if (wr) begin
            exp_q.push_back({1'b0, 2'b01, d});
            m_wr_v     = 1'b1;
            m_wr_a     = a;
            exp_mem[a] = d;
        end else begin
            exp_q.push_back({1'b1, 2'b11, 8'h00});
            m_rd_v = 1'b1;
            m_rd_a = a;
            lat   += R + 9;
            rd     = exp_mem[a];
        end
    endtask

    // slave side: collect the 11 leading bits of each SS_n-low window, feed MISO
    int          bit_cnt = 0;
    logic [10:0] fbits = '0;
    logic [7:0]  s_wr_a = '0;
    logic [7:0]  s_rd_a = '0;

    always @(negedge clk) begin
        logic [11:0] ef;
        logic [7:0]  rb;
        logic [2:0]  idx;
        if (hif.rsp_valid === 1'b1) rsp_q.push_back(hif.rsp_rdata);
        if (ss_n === 1'b0) begin
            if (bit_cnt < 11) fbits = {fbits[9:0], mosi};
            if (bit_cnt >= 11 + R && bit_cnt <= 18 + R && fbits[10:8] == 3'b111) begin
                rb   = smem[s_rd_a];
                idx  = 3'(7 - (bit_cnt - 11 - R));
                miso = rb[idx];
            end else begin
                miso = 1'($urandom_range(0, 1));
            end
            bit_cnt++;
        end else begin
            if (bit_cnt >= 11) begin
                ef = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 12'hFFF;
                chk("frame", 32'(fbits), 32'(ef));
                case (fbits[9:8])
                    2'b00:   s_wr_a = fbits[7:0];
                    2'b01:   smem[s_wr_a] = fbits[7:0];
                    2'b10:   s_rd_a = fbits[7:0];
                    default: ;
                endcase
            end
            bit_cnt = 0;
            miso    = 1'b0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        rsp_q.delete();
        m_wr_v = 1'b0;
        m_rd_v = 1'b0;
    endtask

    task automatic do_req(input bit wr, input logic [7:0] a, input logic [7:0] d);
        int         lat_exp, lat, n, ready_hi;
        logic [7:0] rd_exp;
        model_req(wr, a, d, lat_exp, rd_exp);
        @(negedge clk);
        hif.req_valid = 1'b1;
        hif.req_write = wr;
        hif.req_addr  = a;
        hif.req_wdata = d;
        n = 0;
        while (!hif.req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready", 32'(hif.req_ready), 32'd1);
        @(posedge clk);
        #1;
        hif.req_valid = 1'b0;
        hif.req_write = 1'($urandom);
        hif.req_addr  = 8'($urandom);
        hif.req_wdata = 8'($urandom);
        lat      = 0;
        ready_hi = 0;
        @(negedge clk);
        while (hif.busy && lat < 300) begin
            if (hif.req_ready) ready_hi++;
            lat++;
            @(negedge clk);
        end
        chk(wr ? "wr_latency" : "rd_latency", 32'(lat), 32'(lat_exp));
        chk("ready_while_busy", 32'(ready_hi), 32'd0);
        chk("frames_left", 32'(exp_q.size()), 32'd0);
        chk("rsp_count", 32'(rsp_q.size()), wr ? 32'd0 : 32'd1);
        if (!wr) begin
            if (rsp_q.size() > 0) chk("rdata", 32'(rsp_q.pop_front()), 32'(rd_exp));
            chk("rdata_hold", 32'(hif.rsp_rdata), 32'(rd_exp));
        end
        exp_q.delete();
        rsp_q.delete();
    endtask

    task automatic nc_write(input logic [7:0] a, input logic [7:0] d);
        int   lat, frames, n;
        logic prev;
        @(negedge clk);
        hif_nc.req_valid = 1'b1;
        hif_nc.req_write = 1'b1;
        hif_nc.req_addr  = a;
        hif_nc.req_wdata = d;
        n = 0;
        while (!hif_nc.req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        hif_nc.req_valid = 1'b0;
        lat    = 0;
        frames = 0;
        prev   = 1'b1;
        @(negedge clk);
        while (hif_nc.busy && lat < 300) begin
            if (prev && !ss_n_nc) frames++;
            prev = ss_n_nc;
            lat++;
            @(negedge clk);
        end
        chk("nocache_latency", 32'(lat), 32'(2 * (11 + G)));
        chk("nocache_frames", 32'(frames), 32'd2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int          n, lat_e[3], t_acc[3];
        logic [7:0]  rd_e[3], a6[3], pool[4], v;

        hif.req_valid    = 1'b0;
        hif.req_write    = 1'b0;
        hif.req_addr     = '0;
        hif.req_wdata    = '0;
        hif_nc.req_valid = 1'b0;
        hif_nc.req_write = 1'b0;
        hif_nc.req_addr  = '0;
        hif_nc.req_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            v          = 8'($urandom);
            smem[i]    = v;
            exp_mem[i] = v;
        end

        // reset and idle
        do_reset();
        chk("reset_rdata", 32'(hif.rsp_rdata), 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_outputs", 32'({ss_n, mosi, hif.req_ready, hif.busy, hif.rsp_valid}), 32'b10100);
        end

        // write, read back, cached rewrite
        do_req(1'b1, 8'hA5, 8'h3C);
        chk("ram_a5_write", 32'(smem[8'hA5]), 32'h3C);
        do_req(1'b0, 8'hA5, 8'h00);
        do_req(1'b1, 8'hA5, 8'h5A);
        chk("ram_a5_rewrite", 32'(smem[8'hA5]), 32'h5A);
        do_req(1'b0, 8'hA5, 8'h00);

        nc_write(8'hA5, 8'h11);
        nc_write(8'hA5, 8'h22);

        // reset during SHIFT of a write data frame
        do_reset();
        @(negedge clk);
        exp_q.push_back({1'b0, 2'b00, 8'h33});
        hif.req_valid = 1'b1;
        hif.req_write = 1'b1;
        hif.req_addr  = 8'h33;
        hif.req_wdata = 8'h44;
        @(posedge clk);
        #1;
        hif.req_valid = 1'b0;
        repeat (16 + G) @(negedge clk);
        chk("abort_in_frame", 32'({ss_n, hif.busy}), 32'b01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outputs", 32'({ss_n, hif.busy, hif.req_ready}), 32'b101);
        exp_q.delete();
        m_wr_v = 1'b0;
        m_rd_v = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_no_rsp", 32'(rsp_q.size()), 32'd0);
        chk("abort_no_write", 32'(smem[8'h33]), 32'(exp_mem[8'h33]));
        do_req(1'b1, 8'h33, 8'h55);
        chk("ram_33_after_abort", 32'(smem[8'h33]), 32'h55);

        // req_valid held across three reads
        a6[0] = 8'h00;
        a6[1] = 8'h7F;
        a6[2] = 8'hFF;
        for (int i = 0; i < 3; i++) model_req(1'b0, a6[i], 8'h00, lat_e[i], rd_e[i]);
        @(negedge clk);
        hif.req_valid = 1'b1;
        hif.req_write = 1'b0;
        hif.req_addr  = a6[0];
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!hif.req_ready && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_ready", 32'(hif.req_ready), 32'd1);
            @(posedge clk);
            #1;
            t_acc[i] = cyc;
            if (i < 2) hif.req_addr = a6[i+1];
            else hif.req_valid = 1'b0;
            @(negedge clk);
            chk("b2b_ready_low", 32'(hif.req_ready), 32'd0);
        end
        n = 0;
        while (hif.busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        for (int i = 1; i < 3; i++) chk("b2b_accept_gap", 32'(t_acc[i] - t_acc[i-1]), 32'(lat_e[i-1] + 1));
        chk("b2b_rsp_count", 32'(rsp_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (rsp_q.size() > 0) chk("b2b_rdata", 32'(rsp_q.pop_front()), 32'(rd_e[i]));
        end
        chk("b2b_frames_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        rsp_q.delete();

        // random mix over a small address pool so both caches hit and miss
        for (int i = 0; i < 4; i++) pool[i] = 8'($urandom);
        for (int i = 0; i < 40; i++) begin
            do_req(1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)], 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
